pix_write_framer: RTL
=====================

Name: pix_write_framer

Overview:
- Sits between the SPI slave pixel output (24-bit RGB + one-cycle trigger) and the MMU SDRAM write path.
- Assigns each received pixel an SDRAM word address from its image slot and pixel position, and buffers pixel/address pairs in a small FIFO.
- Presents the FIFO head to the MMU with a valid/ready handshake and reports image completion, image count and overflow.
- Single 50 MHz system clock domain.

Parameters:
- H_RES, 800, pixels per line
- V_RES, 480, lines per image; FRAME = H_RES*V_RES pixels per image
- MAX_IMG, 8, number of image slots in SDRAM
- FIFO_DEPTH, 16, FIFO entries, power of two, at least 2
- ADDR_W, 24, SDRAM word address width

Ports:
- iCLK  in  1  system clock, 50 MHz
- iRSTN  in  1  asynchronous active-low reset
- iPix_Data  in  24  RGB pixel from the SPI slave
- iTrigger  in  1  one-cycle pulse; iPix_Data is valid in this cycle
- iRestart  in  1  synchronous pulse; restart loading from slot 0
- oWr_Data  out  32  {8'h00, RGB} at the FIFO head
- oWr_Addr  out  ADDR_W  word address at the FIFO head
- oWr_Valid  out  1  FIFO head is valid
- iWr_Ready  in  1  MMU accepts the head this cycle
- oImg_Done  out  1  one-cycle pulse when an image's last pixel is taken
- oImg_Cnt  out  8  number of completed images
- oOverflow  out  1  sticky; a pixel was dropped because the FIFO was full
- oLevel  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (iRSTN low, asynchronous): FIFO empty, oWr_Valid=0, oWr_Data=0, oWr_Addr=0, oImg_Done=0, oImg_Cnt=0, oOverflow=0, oLevel=0, pixel index=0, image base=0, state=S_IDLE.
- States:
  - S_IDLE: no pixel of the current image received yet.
  - S_RECV: at least one pixel of the current image received.
  - S_DONE: oImg_Cnt == MAX_IMG; every iTrigger is ignored (no push, no index advance, oOverflow unchanged).
- Transitions:
  - S_IDLE -> S_RECV on an iTrigger.
  - On an iTrigger with index == FRAME-1: index -> 0, base += FRAME, oImg_Cnt += 1, oImg_Done pulses in the next cycle, next state S_IDLE.
  - If the new oImg_Cnt == MAX_IMG, next state is S_DONE instead of S_IDLE.
- Address:
  - Address = base + index, truncated to ADDR_W.
  - base is a running accumulator; no multiplier.
- Push:
  - On iTrigger in S_IDLE/S_RECV: if FIFO not full, push {address, pixel}.
  - If FIFO full: drop the pixel, set oOverflow. The index still advances so image geometry stays aligned with the sender.
  - "Full" is evaluated on the registered level before this cycle's pop. A pop in the same cycle does not make room for a simultaneous push.
- Pop:
  - A transfer occurs when oWr_Valid && iWr_Ready.
  - oWr_Data/oWr_Addr are show-ahead and remain stable while oWr_Valid=1 and iWr_Ready=0.
- Latency: a trigger into an empty FIFO at cycle N gives oWr_Valid=1 at cycle N+1.
- Simultaneous push and pop with a non-full FIFO: level unchanged; both take effect.
- iRestart (checked before iTrigger):
  - Next cycle: FIFO flushed (oWr_Valid=0, oLevel=0), index=0, base=0, oImg_Cnt=0, oOverflow=0, state S_IDLE.
  - A trigger in the same cycle is discarded and does not set oOverflow.
  - A pending oImg_Done is cancelled.
- Asynchronous reset mid-image has the same effect as iRestart, applied immediately.
- oImg_Cnt saturates at MAX_IMG. Pointers wrap modulo FIFO_DEPTH.

Optional Feature:
- Macro: PIX_WRITE_FRAMER_DROP_CNT_EN.
- Defined:
  - Adds output port oDrop_Cnt, 16 bits.
  - Increments on every pixel dropped because the FIFO was full.
  - Saturates at 16'hFFFF.
  - Cleared by reset or iRestart.
  - Triggers ignored in S_DONE are not counted.
- Undefined: the port and its counter are absent. All other behaviour is identical.

Test Plan:
(Bench uses H_RES=4, V_RES=2, MAX_IMG=2, FIFO_DEPTH=4, ADDR_W=8.)
- Basic stream: iWr_Ready=1; 8 triggers with data 0x000001..0x000008 -> writes at addresses 0..7 with data 0x00000001..0x00000008; oImg_Done pulses once, in the cycle after the 8th trigger; oImg_Cnt=1.
- Two images: 16 triggers -> addresses 8..15 for the second image; oImg_Cnt=2; state S_DONE; a 17th trigger produces no write and oOverflow stays 0.
- Backpressure: iWr_Ready=0, 6 triggers -> oLevel=4, oOverflow=1, DROP_CNT=2. Release ready -> exactly 4 writes, to addresses 0..3. The next trigger gets address 6.
- Full with pop: FIFO full and iWr_Ready=1 when a trigger arrives -> that pixel is dropped and one entry pops; oLevel=3.
- Restart: after 5 pixels with 2 still queued, pulse iRestart with a trigger in the same cycle -> next cycle oWr_Valid=0, oImg_Cnt=0, oOverflow=0; the next trigger is written at address 0.
- Async reset: drop iRSTN mid-image with 3 entries queued -> all outputs 0 immediately; after release, the first pixel is written at address 0.

Source files
------------

// File: rtl/pix_write_framer.sv
// pix_write_framer
// Takes pixels from the SPI slave (24-bit RGB plus a one-cycle trigger),
// tags each with its SDRAM word address (image slot base + pixel index),
// queues the pixel/address pairs in a small show-ahead FIFO and offers the
// FIFO head to the MMU with a valid/ready handshake. It also reports image
// completion, the completed image count and a sticky overflow flag.
//
// Optional build macro: PIX_WRITE_FRAMER_DROP_CNT_EN
//   When defined, adds the 16-bit output oDrop_Cnt, a saturating count of
//   pixels dropped because the FIFO was full. It is cleared by reset or by
//   iRestart. When undefined, the port and the counter do not exist.

module pix_write_framer #(
    parameter int H_RES      = 800,
    parameter int V_RES      = 480,
    parameter int MAX_IMG    = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_W     = 24
) (
    input  logic                          iCLK,
    input  logic                          iRSTN,
    input  logic [23:0]                   iPix_Data,
    input  logic                          iTrigger,
    input  logic                          iRestart,
    output logic [31:0]                   oWr_Data,
    output logic [ADDR_W-1:0]             oWr_Addr,
    output logic                          oWr_Valid,
    input  logic                          iWr_Ready,
    output logic                          oImg_Done,
    output logic [7:0]                    oImg_Cnt,
    output logic                          oOverflow,
    output logic [$clog2(FIFO_DEPTH):0]   oLevel
`ifdef PIX_WRITE_FRAMER_DROP_CNT_EN
    ,
    output logic [15:0]                   oDrop_Cnt
`endif
);

    // Geometry and sizing derived from the parameters
    localparam int FRAME = H_RES * V_RES;
    localparam int IDX_W = (FRAME > 1) ? $clog2(FRAME) : 1;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LVL_W = PTR_W + 1;

    localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(FRAME - 1);
    localparam logic [ADDR_W-1:0] FRAME_STEP = ADDR_W'(FRAME);
    localparam logic [7:0]        IMG_MAX    = 8'(MAX_IMG);
    localparam logic [LVL_W-1:0]  LVL_FULL   = LVL_W'(FIFO_DEPTH);

    // Frame-tracking states
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RECV = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Control and bookkeeping registers
    logic [1:0]        state_q,     state_d;
    logic [IDX_W-1:0]  pixIdx_q,    pixIdx_d;
    logic [ADDR_W-1:0] imgBase_q,   imgBase_d;
    logic [7:0]        imgCnt_q,    imgCnt_d;
    logic              imgDone_q,   imgDone_d;
    logic              overflow_q,  overflow_d;
`ifdef PIX_WRITE_FRAMER_DROP_CNT_EN
    logic [15:0]       dropCnt_q,   dropCnt_d;
`endif

    // FIFO pointers and occupancy
    logic [PTR_W-1:0]  wrPtr_q,     wrPtr_d;
    logic [PTR_W-1:0]  rdPtr_q,     rdPtr_d;
    logic [LVL_W-1:0]  level_q,     level_d;

    // FIFO storage; not reset, the outputs are gated by the valid flag
    logic [23:0]       pixMem  [FIFO_DEPTH];
    logic [ADDR_W-1:0] addrMem [FIFO_DEPTH];

    // Per-cycle decisions
    logic              fifoFull;
    logic              fifoValid;
    logic              popEn;
    logic              trigAccept;
    logic              pushEn;
    logic              dropEn;
    logic              lastPix;
    logic [ADDR_W-1:0] curAddr;

    // Derive handshake, push/drop decisions and the current pixel address.
    // Full is taken from the registered level, so a same-cycle pop never
    // makes room for a push. iRestart takes priority over any trigger.
    always_comb begin
        fifoFull   = (level_q == LVL_FULL);
        fifoValid  = (level_q != '0);
        popEn      = fifoValid && iWr_Ready;
        trigAccept = iTrigger && !iRestart && (state_q != S_DONE);
        pushEn     = trigAccept && !fifoFull;
        dropEn     = trigAccept && fifoFull;
        lastPix    = (pixIdx_q == LAST_IDX);
        curAddr    = imgBase_q + ADDR_W'(pixIdx_q);
    end

    // Frame position, image slot base, completion, count and overflow.
    // The index advances on every accepted trigger, even a dropped one, so
    // the image geometry stays locked to the sender.
    always_comb begin
        state_d    = state_q;
        pixIdx_d   = pixIdx_q;
        imgBase_d  = imgBase_q;
        imgCnt_d   = imgCnt_q;
        imgDone_d  = 1'b0;
        overflow_d = overflow_q;
`ifdef PIX_WRITE_FRAMER_DROP_CNT_EN
        dropCnt_d  = dropCnt_q;
`endif
        if (iRestart) begin
            state_d    = S_IDLE;
            pixIdx_d   = '0;
            imgBase_d  = '0;
            imgCnt_d   = '0;
            overflow_d = 1'b0;
`ifdef PIX_WRITE_FRAMER_DROP_CNT_EN
            dropCnt_d  = '0;
`endif
        end else if (trigAccept) begin
            if (lastPix) begin
                pixIdx_d  = '0;
                imgBase_d = imgBase_q + FRAME_STEP;
                imgDone_d = 1'b1;
                if (imgCnt_q != IMG_MAX) begin
                    imgCnt_d = imgCnt_q + 8'd1;
                end
                if ((imgCnt_q + 8'd1) >= IMG_MAX) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_IDLE;
                end
            end else begin
                pixIdx_d = pixIdx_q + IDX_W'(1);
                state_d  = S_RECV;
            end
            if (dropEn) begin
                overflow_d = 1'b1;
`ifdef PIX_WRITE_FRAMER_DROP_CNT_EN
                if (dropCnt_q != 16'hFFFF) begin
                    dropCnt_d = dropCnt_q + 16'd1;
                end
`endif
            end
        end
    end

    // FIFO pointer and occupancy update; iRestart flushes the queue
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        level_d = level_q;
        if (iRestart) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            level_d = '0;
        end else begin
            if (pushEn) begin
                wrPtr_d = wrPtr_q + PTR_W'(1);
            end
            if (popEn) begin
                rdPtr_d = rdPtr_q + PTR_W'(1);
            end
            case ({pushEn, popEn})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase
        end
    end

    // Register all control state with asynchronous active-low reset
    always_ff @(posedge iCLK or negedge iRSTN) begin
        if (!iRSTN) begin
            state_q    <= S_IDLE;
            pixIdx_q   <= '0;
            imgBase_q  <= '0;
            imgCnt_q   <= '0;
            imgDone_q  <= 1'b0;
            overflow_q <= 1'b0;
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            level_q    <= '0;
`ifdef PIX_WRITE_FRAMER_DROP_CNT_EN
            dropCnt_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            pixIdx_q   <= pixIdx_d;
            imgBase_q  <= imgBase_d;
            imgCnt_q   <= imgCnt_d;
            imgDone_q  <= imgDone_d;
            overflow_q <= overflow_d;
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            level_q    <= level_d;
`ifdef PIX_WRITE_FRAMER_DROP_CNT_EN
            dropCnt_q  <= dropCnt_d;
`endif
        end
    end

    // Write the pixel and its address into the FIFO slot at the write pointer
    always_ff @(posedge iCLK) begin
        if (pushEn) begin
            pixMem[wrPtr_q]  <= iPix_Data;
            addrMem[wrPtr_q] <= curAddr;
        end
    end

    // Show-ahead head of the FIFO, forced to zero while the FIFO is empty
    always_comb begin
        oWr_Valid = fifoValid;
        oWr_Data  = 32'h0;
        oWr_Addr  = '0;
        if (fifoValid) begin
            oWr_Data = {8'h00, pixMem[rdPtr_q]};
            oWr_Addr = addrMem[rdPtr_q];
        end
    end

    assign oImg_Done = imgDone_q;
    assign oImg_Cnt  = imgCnt_q;
    assign oOverflow = overflow_q;
    assign oLevel    = level_q;
`ifdef PIX_WRITE_FRAMER_DROP_CNT_EN
    assign oDrop_Cnt = dropCnt_q;
`endif

endmodule
